// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with a four-phase REQ/ACK handshake to the processor.
// Optional feature: define IRQ_ROUND_ROBIN_EN for rotating priority (fixed lowest-index priority otherwise).
module irq_controller #(
  parameter int          N     = 64,
  parameter int          NCH   = 4,
  parameter logic [63:0] VBASE = 64'h0
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NCH-1:0]         irq_in,
  input  logic                   en_we,
  input  logic [NCH-1:0]         en_wdata,
  input  logic                   ExtIAck,
  output logic                   ExtIRQ,
  output logic [$clog2(NCH)-1:0] irq_id,
  output logic [N-1:0]           irq_cause,
  output logic [NCH-1:0]         pending,
  output logic [1:0]             state_dbg
);
  localparam int IDW = $clog2(NCH);
  localparam logic [N-1:0] VBASE_N = N'(VBASE);

  // Handshake: ExtIRQ rises in REQ and holds irq_id/irq_cause stable until ExtIAck=1;
  // the controller then drops ExtIRQ and waits for ExtIAck=0 before it may request again.
  typedef enum logic [1:0] {IDLE, REQ, ACK, RELEASE} state_t;

  state_t         state, state_nx;
  logic [NCH-1:0] irq_prev;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] clr_mask;
  logic [IDW-1:0] sel_id;
  logic           found;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pending & enable;
  assign clr_mask = (state == ACK) ? (NCH'(1) << irq_id) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDW-1:0] last_id;
  logic [IDW:0]   cand;

  // Search starts one past the last served channel and wraps modulo NCH.
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, last_id} + (IDW+1)'(k + 1);
      if (cand >= (IDW+1)'(NCH)) cand = cand - (IDW+1)'(NCH);
      if (!found && eligible[cand[IDW-1:0]]) begin
        found  = 1'b1;
        sel_id = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)                                      last_id <= IDW'(NCH - 1);
    else if (state == IDLE && eligible != '0)       last_id <= sel_id;
  end
`else
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && eligible[i]) begin
        found  = 1'b1;
        sel_id = IDW'(i);
      end
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found)    state_nx = REQ;
      REQ:     if (ExtIAck)  state_nx = ACK;
      ACK:                   state_nx = RELEASE;
      RELEASE: if (!ExtIAck) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // A fresh rise on the channel being cleared overrides the clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      enable   <= '1;
      irq_id   <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~clr_mask) | rise;
      if (en_we) enable <= en_wdata;
      if (state == IDLE && found) irq_id <= sel_id;
    end
  end

  assign ExtIRQ    = (state == REQ);
  assign irq_cause = VBASE_N + N'(irq_id);
  assign state_dbg = state;
endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed bench for irq_controller, checked against a rule-level model.
module tb_irq_controller;
  localparam int          N     = 64;
  localparam int          NCH   = 4;
  localparam logic [63:0] VBASE = 64'hFFFF_FFFF_FFFF_FFFE;

  localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_REL = 3;

  logic           CLOCK_50 = 1'b0;
  logic           reset    = 1'b1;
  logic [NCH-1:0] irq_in   = '0;
  logic           en_we    = 1'b0;
  logic [NCH-1:0] en_wdata = '0;
  logic           ExtIAck  = 1'b0;
  logic           ExtIRQ;
  logic [1:0]     irq_id;
  logic [N-1:0]   irq_cause;
  logic [NCH-1:0] pending;
  logic [1:0]     state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [NCH-1:0] m_pend = '0, m_en = '1, m_prev = '0;
  int             m_phase = P_IDLE, m_id = 0, m_last = NCH - 1;
  logic [1:0]     exp_q[$];
  logic           extirq_d = 1'b0;

  irq_controller #(.N(N), .NCH(NCH), .VBASE(VBASE)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .irq_in   (irq_in),
    .en_we    (en_we),
    .en_wdata (en_wdata),
    .ExtIAck  (ExtIAck),
    .ExtIRQ   (ExtIRQ),
    .irq_id   (irq_id),
    .irq_cause(irq_cause),
    .pending  (pending),
    .state_dbg(state_dbg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] el, input int last);
`ifdef IRQ_ROUND_ROBIN_EN
    for (int k = 1; k <= NCH; k++)
      if (el[(last + k) % NCH]) return (last + k) % NCH;
`else
    for (int i = 0; i < NCH; i++)
      if (el[i]) return i;
`endif
    return 0;
  endfunction

  // Applies the controller's rules to the inputs present at this clock edge.
  task automatic model_update();
    logic [NCH-1:0] el;
    logic [NCH-1:0] clr;
    if (reset) begin
      m_pend = '0; m_en = '1; m_prev = '0;
      m_phase = P_IDLE; m_id = 0; m_last = NCH - 1;
      exp_q.delete();
      return;
    end
    el  = m_pend & m_en;
    clr = (m_phase == P_ACK) ? NCH'(1 << m_id) : '0;
    m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
    m_prev = irq_in;
    if (en_we) m_en = en_wdata;
    case (m_phase)
      P_IDLE: if (el != 0) begin
        m_id = pick(el, m_last);
        m_last = m_id;
        m_phase = P_REQ;
        exp_q.push_back(2'(m_id));
      end
      P_REQ:  if (ExtIAck) m_phase = P_ACK;
      P_ACK:  m_phase = P_REL;
      default: if (!ExtIAck) m_phase = P_IDLE;
    endcase
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_update();
    #1;
    check("extirq",  64'(ExtIRQ),  64'(m_phase == P_REQ));
    check("irq_id",  64'(irq_id),  64'(m_id));
    check("cause",   irq_cause,    VBASE + 64'(m_id));
    check("pending", 64'(pending), 64'(m_pend));
    if (ExtIRQ && !extirq_d) begin
      if (exp_q.size() == 0) check("sb_empty", 64'(1), 64'(0));
      else check("sb_id", 64'(irq_id), 64'(exp_q.pop_front()));
    end
    extirq_d = ExtIRQ;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !ExtIRQ; i++) step();
    check("req_timeout", 64'(ExtIRQ), 64'(1));
  endtask

  task automatic serve();
    ExtIAck = 1'b1; step(); step();
    ExtIAck = 1'b0; step();
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    irq_in = m; step();
    irq_in = '0;
  endtask

  initial begin
    logic [1:0] prev_id;
    step(); step();
    check("rst_extirq", 64'(ExtIRQ), 64'(0));
    check("rst_id",     64'(irq_id), 64'(0));
    check("rst_cause",  irq_cause,   VBASE);
    check("rst_pend",   64'(pending), 64'(0));
    reset = 1'b0;
    step();

    // Single request on channel 2, cause wraps modulo 2^64.
    pulse(4'b0100);
    check("p2_pend", 64'(pending), 64'(4'b0100));
    step();
    check("p2_irq",   64'(ExtIRQ), 64'(1));
    check("p2_id",    64'(irq_id), 64'(2));
    check("p2_cause", irq_cause,   VBASE + 64'd2);
    ExtIAck = 1'b1; step();
    check("p2_ack_irq", 64'(ExtIRQ), 64'(0));
    step();
    check("p2_clr", 64'(pending), 64'(0));
    ExtIAck = 1'b0; step();

    // Two simultaneous sources.
    pulse(4'b1010);
    wait_req();
`ifndef IRQ_ROUND_ROBIN_EN
    check("prio_first", 64'(irq_id), 64'(1));
`endif
    serve();
    wait_req();
`ifndef IRQ_ROUND_ROBIN_EN
    check("prio_second", 64'(irq_id), 64'(3));
`endif
    serve();

`ifdef IRQ_ROUND_ROBIN_EN
    prev_id = 2'd0;
    for (int k = 0; k < 4; k++) begin
      pulse(4'b0011);
      wait_req();
      if (k > 0) check("rr_alt", 64'(irq_id), 64'(prev_id ^ 2'd1));
      prev_id = irq_id;
      serve();
    end
    pulse(4'b0011);
    step(); step(); serve(); step(); serve();
`endif

    // Disabled channel pends but does not request.
    en_we = 1'b1; en_wdata = 4'b1110; step(); en_we = 1'b0;
    pulse(4'b0001);
    step(); step(); step();
    check("dis_pend", 64'(pending), 64'(4'b0001));
    check("dis_irq",  64'(ExtIRQ),  64'(0));
    en_we = 1'b1; en_wdata = 4'b1111; step(); en_we = 1'b0;
    wait_req();
    check("en_id", 64'(irq_id), 64'(0));
    serve();

    // Reset during REQ, source held high across release.
    pulse(4'b0001);
    wait_req();
    reset = 1'b1; irq_in = 4'b1000; step();
    check("rreq_irq",  64'(ExtIRQ),  64'(0));
    check("rreq_pend", 64'(pending), 64'(0));
    step();
    reset = 1'b0; step();
    check("rel_pend", 64'(pending), 64'(4'b1000));
    wait_req();
    check("rel_id", 64'(irq_id), 64'(3));
    serve();
    step(); step();
    check("level_once", 64'(pending), 64'(0));
    check("level_irq",  64'(ExtIRQ),  64'(0));
    irq_in = '0; step();

    // New edge on the channel during its ACK cycle.
    pulse(4'b0100);
    wait_req();
    ExtIAck = 1'b1; step();
    irq_in = 4'b0100; step();
    check("ack_set_wins", 64'(pending[2]), 64'(1));
    irq_in = '0; ExtIAck = 1'b0; step();
    wait_req();
    check("ack_rerequest", 64'(irq_id), 64'(2));
    serve();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = NCH'($urandom_range(0, 15));
      en_we    = ($urandom_range(0, 15) == 0);
      en_wdata = NCH'($urandom_range(0, 15));
      ExtIAck  = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; en_we = 1'b0; irq_in = '0; ExtIAck = 1'b0;
    step(); step();
    check("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N, default 64, width of the vector/cause word returned to the processor.
REQ-002 Parameter NCH, default 4, number of external interrupt channels, range 2..16.
REQ-003 Parameter VBASE, default 64'h0, base value for the interrupt cause word.
REQ-004 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 irq_in  input  NCH  raw level interrupt sources, already synchronous to CLOCK_50.
REQ-007 en_we  input  1  write strobe for the channel-enable register.
REQ-008 en_wdata  input  NCH  new channel-enable value; bit=1 enables that channel.
REQ-009 ExtIAck  input  1  processor acknowledge of the current request.
REQ-010 ExtIRQ  output  1  interrupt request to the processor.
REQ-011 irq_id  output  $clog2(NCH)  channel currently being requested.
REQ-012 irq_cause  output  N  VBASE + irq_id, zero-extended to N bits.
REQ-013 pending  output  NCH  current pending register, for debug/dump.

Function
REQ-014 A rising edge on irq_in[i] (current 1, previous sample 0) SHALL set pending[i] on the next edge, regardless of enable.
REQ-015 Eligible set = pending & enable; requests are made only from eligible channels.
REQ-016 FSM states: IDLE, REQ, ACK, RELEASE.
REQ-017 IDLE: ExtIRQ=0; if the eligible set is non-zero, latch the selected channel into irq_id and enter REQ on the next edge.
REQ-018 REQ: ExtIRQ=1, irq_id and irq_cause held stable; stay until ExtIAck=1, then enter ACK.
REQ-019 ACK: for exactly one cycle, clear pending[irq_id] and drive ExtIRQ=0, then enter RELEASE.
REQ-020 RELEASE: ExtIRQ=0; stay until ExtIAck=0, then enter IDLE. Minimum re-request gap is therefore 2 cycles after ExtIAck falls.
REQ-021 If ExtIAck is already 1 on entry to REQ, the controller SHALL still spend one cycle in REQ with ExtIRQ=1 before entering ACK.
REQ-022 If a new edge on channel irq_id coincides with the ACK-cycle clear, the set SHALL win and pending stays 1.
REQ-023 If the requested channel is disabled through en_we while in REQ, the request SHALL be held until acknowledged; no withdrawal.
REQ-024 en_we takes effect on the next edge and updates the eligible set for the following cycle.
REQ-025 Sources held high produce only one pending event; a level is not re-pended until irq_in falls and rises again.
REQ-026 irq_cause = VBASE + irq_id, computed modulo 2^N; it is valid whenever ExtIRQ=1.

Reset
REQ-027 On reset the controller SHALL set: state=IDLE, ExtIRQ=0, irq_id=0, irq_cause=VBASE, pending=0, enable=all ones, edge-detect history=0.
REQ-028 Reset asserted in any state SHALL abandon the current request with no acknowledge required; an interrupted request is lost.
REQ-029 When reset is deasserted, a source already high SHALL register as an edge on the first active cycle.

Configuration
REQ-030 When the macro IRQ_ROUND_ROBIN_EN is defined, the selection SHALL be rotating priority. The search starts at (last served id + 1) mod NCH. The last served id resets to NCH-1.
REQ-031 When IRQ_ROUND_ROBIN_EN is not defined, the selection SHALL be fixed priority, with the lowest index winning.

Verification
REQ-032 Pulse irq_in[2] with NCH=4 -> ExtIRQ=1 two cycles later, with irq_id=2 and irq_cause=VBASE+2. Raise ExtIAck -> pending[2]=0 and ExtIRQ=0 after the ACK cycle.
REQ-033 Raise irq_in[1] and irq_in[3] in the same cycle, with fixed priority -> id 1 is served first, then id 3 after ExtIAck falls.
REQ-034 With IRQ_ROUND_ROBIN_EN, keep channels 0 and 1 re-pulsing -> the served ids alternate 0,1,0,1.
REQ-035 Write en_wdata=4'b1110, then pulse irq_in[0] -> pending[0]=1 and ExtIRQ stays 0. Write 4'b1111 -> request id 0 follows.
REQ-036 Assert reset in the REQ state -> ExtIRQ=0 and pending=0 the next cycle. Hold irq_in[3] high across reset release -> a request for id 3 follows.
REQ-037 Pulse irq_in[2] on the ACK-cycle of id 2 -> pending[2] remains 1 and a second request for id 2 follows.
